// File: rtl/ycr_clk_ctrl_pkg.sv
// Shared types and constants for the source-side clock-gate control path.
package ycr_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_QUIET,
        ST_IDLE,
        ST_WAKE
    } idle_st_t;

    localparam int TMR_W  = 8;
    localparam int WAKE_W = 4;

    // Wake default covers the gate's 2-flop synchronisers plus margin.
    localparam logic [TMR_W-1:0]  IDLE_CYC_DEF = 8'd8;
    localparam logic [WAKE_W-1:0] WAKE_CYC_DEF = 4'd3;

endpackage

// File: rtl/ycr_idle_timer.sv
// Loadable down-counter shared by the QUIET and WAKE phases; holds at zero.
module ycr_idle_timer
    import ycr_clk_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = load_val;
        end else if (dec && (timer_q != '0)) begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign zero = (timer_q == '0);

endmodule

// File: rtl/ycr_clk_idle_mon.sv
// Tracks in-flight requests, declares the destination idle after a quiet
// period and stalls upstream while the clock gate wakes the destination.
module ycr_clk_idle_mon
    import ycr_clk_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTD = 8,
    parameter int CW         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_enb,
    input  logic [TMR_W-1:0]  cfg_idle_cyc,
    input  logic [WAKE_W-1:0] cfg_wake_cyc,
    input  logic              up_req_vld,
    output logic              up_req_rdy,
    output logic              dn_req_vld,
    input  logic              dn_req_rdy,
    input  logic              dn_rsp_vld,
    input  logic              ext_wake,
    output logic              dst_idle,
    output logic              src_req,
    output logic [CW-1:0]     outstd_cnt,
    output logic              err_unf
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTD);

    idle_st_t         st_q, st_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             dst_idle_q, src_req_q;
    logic             open_st, acc, rsp;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    assign open_st    = (st_q == ST_ACTIVE) || (st_q == ST_QUIET);
    assign dn_req_vld = up_req_vld & open_st;
    assign up_req_rdy = dn_req_rdy & open_st & (cnt_q != MAX_CNT);
    assign acc        = up_req_vld & up_req_rdy;
    assign rsp        = dn_rsp_vld;

    // A response with nothing outstanding is a protocol error; the count stays at zero.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (acc && !rsp) begin
            cnt_d = cnt_q + CW'(1);
        end else if (rsp && !acc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        st_d     = st_q;
        tmr_load = 1'b0;
        tmr_val  = cfg_idle_cyc;
        tmr_dec  = 1'b0;
        case (st_q)
            ST_ACTIVE: begin
                if (cfg_enb && (cnt_d == '0) && !acc && !rsp && !ext_wake) begin
                    st_d     = ST_QUIET;
                    tmr_load = 1'b1;
                    tmr_val  = cfg_idle_cyc;
                end
            end
            ST_QUIET: begin
                // Any sign of traffic, even a request not yet accepted, aborts the countdown.
                if (acc || rsp || ext_wake || !cfg_enb || up_req_vld) begin
                    st_d = ST_ACTIVE;
                end else if (tmr_zero) begin
                    st_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_IDLE: begin
                if (up_req_vld || ext_wake || !cfg_enb) begin
                    st_d     = ST_WAKE;
                    tmr_load = 1'b1;
                    tmr_val  = {{(TMR_W-WAKE_W){1'b0}}, cfg_wake_cyc};
                end
            end
            ST_WAKE: begin
                if (tmr_zero) begin
                    st_d = ST_ACTIVE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: st_d = ST_ACTIVE;
        endcase
    end

    ycr_idle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_ACTIVE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            dst_idle_q <= 1'b0;
            src_req_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            dst_idle_q <= (st_d == ST_IDLE);
            src_req_q  <= (st_d == ST_WAKE);
        end
    end

    assign dst_idle   = dst_idle_q;
    assign src_req    = src_req_q;
    assign outstd_cnt = cnt_q;
    assign err_unf    = err_q;

endmodule

// File: tb/tb_ycr_clk_idle_mon.sv
// Self-checking bench for ycr_clk_idle_mon: a vector table plus hand-written
// multi-cycle sequences, each cycle's expectation queued and then compared.
module tb_ycr_clk_idle_mon;

    typedef struct packed {
        logic       rdy;
        logic       dnv;
        logic       idle;
        logic       sreq;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic rst;
        logic enb;
        logic vld;
        logic drdy;
        logic rsp;
        logic ext;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_enb;
    logic [7:0] cfg_idle_cyc;
    logic [3:0] cfg_wake_cyc;
    logic       up_req_vld;
    logic       up_req_rdy;
    logic       dn_req_vld;
    logic       dn_req_rdy;
    logic       dn_rsp_vld;
    logic       ext_wake;
    logic       dst_idle;
    logic       src_req;
    logic [3:0] outstd_cnt;
    logic       err_unf;

    int   n_err  = 0;
    int   n_chk  = 0;
    int   n_step = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    ycr_clk_idle_mon #(.MAX_OUTSTD(8), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_enb      (cfg_enb),
        .cfg_idle_cyc (cfg_idle_cyc),
        .cfg_wake_cyc (cfg_wake_cyc),
        .up_req_vld   (up_req_vld),
        .up_req_rdy   (up_req_rdy),
        .dn_req_vld   (dn_req_vld),
        .dn_req_rdy   (dn_req_rdy),
        .dn_rsp_vld   (dn_rsp_vld),
        .ext_wake     (ext_wake),
        .dst_idle     (dst_idle),
        .src_req      (src_req),
        .outstd_cnt   (outstd_cnt),
        .err_unf      (err_unf)
    );

    function automatic exp_t mk(input logic rdy, dnv, idle, sreq, input logic [3:0] cnt, input logic err);
        exp_t e;
        e.rdy = rdy; e.dnv = dnv; e.idle = idle; e.sreq = sreq; e.cnt = cnt; e.err = err;
        return e;
    endfunction

    function automatic vec_t mv(input logic r, en, v, dr, rs, ew, input exp_t e);
        vec_t t;
        t.rst = r; t.enb = en; t.vld = v; t.drdy = dr; t.rsp = rs; t.ext = ew; t.e = e;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, n_step, act, req);
        end
    endtask

    // Outputs observed during a cycle: combinational ones follow this cycle's
    // inputs, registered ones reflect the state entered at the previous edge.
    task automatic compare_head();
        exp_t e;
        e = exp_q.pop_front();
        chk("up_req_rdy", {3'b0, up_req_rdy}, {3'b0, e.rdy});
        chk("dn_req_vld", {3'b0, dn_req_vld}, {3'b0, e.dnv});
        chk("dst_idle",   {3'b0, dst_idle},   {3'b0, e.idle});
        chk("src_req",    {3'b0, src_req},    {3'b0, e.sreq});
        chk("outstd_cnt", outstd_cnt,         e.cnt);
        chk("err_unf",    {3'b0, err_unf},    {3'b0, e.err});
        $display("step %0d rst=%0b enb=%0b vld=%0b drdy=%0b rsp=%0b ext=%0b -> rdy=%0b dnv=%0b idle=%0b sreq=%0b cnt=%0d err=%0b",
                 n_step, rst, cfg_enb, up_req_vld, dn_req_rdy, dn_rsp_vld, ext_wake,
                 up_req_rdy, dn_req_vld, dst_idle, src_req, outstd_cnt, err_unf);
        n_step++;
    endtask

    task automatic step(input logic r, en, v, dr, rs, ew, input exp_t e);
        @(negedge clk);
        rst = r; cfg_enb = en; up_req_vld = v; dn_req_rdy = dr; dn_rsp_vld = rs; ext_wake = ew;
        exp_q.push_back(e);
        #1;
        compare_head();
    endtask

    initial begin
        rst = 1'b1; cfg_enb = 1'b0; cfg_idle_cyc = 8'd4; cfg_wake_cyc = 4'd3;
        up_req_vld = 1'b0; dn_req_rdy = 1'b1; dn_rsp_vld = 1'b0; ext_wake = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and fill/underflow-free counting with idle detection off.
        tbl.push_back(mv(0, 0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0)));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mv(0, 0, 1, 1, 0, 0, mk(1, 1, 0, 0, 4'(k), 0)));
        tbl.push_back(mv(0, 0, 1, 1, 0, 0, mk(0, 1, 0, 0, 8, 0)));
        tbl.push_back(mv(0, 0, 1, 1, 1, 0, mk(0, 1, 0, 0, 8, 0)));
        tbl.push_back(mv(0, 0, 1, 1, 1, 0, mk(1, 1, 0, 0, 7, 0)));
        tbl.push_back(mv(0, 0, 1, 1, 0, 0, mk(1, 1, 0, 0, 7, 0)));
        tbl.push_back(mv(0, 0, 0, 1, 1, 0, mk(0, 0, 0, 0, 8, 0)));
        for (int k = 7; k > 0; k--)
            tbl.push_back(mv(0, 0, 0, 1, 1, 0, mk(1, 0, 0, 0, 4'(k), 0)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0)));
        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].enb, tbl[i].vld, tbl[i].drdy, tbl[i].rsp, tbl[i].ext, tbl[i].e);

        // Idle entry: rsp cycle blocks QUIET, one ACTIVE cycle, then five QUIET cycles.
        step(0, 0, 1, 1, 0, 0, mk(1, 1, 0, 0, 0, 0));
        step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 1, 0));
        step(0, 1, 0, 1, 1, 0, mk(1, 0, 0, 0, 1, 0));
        repeat (6) step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));

        // Wake on held request: four WAKE cycles, then the first acceptance.
        step(0, 1, 1, 1, 0, 0, mk(0, 0, 1, 0, 0, 0));
        repeat (4) step(0, 1, 1, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
        step(0, 1, 1, 1, 0, 0, mk(1, 1, 0, 0, 0, 0));
        step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 1, 0));
        step(0, 1, 0, 1, 1, 0, mk(1, 0, 0, 0, 1, 0));

        // ext_wake pulse with the timer at 2 restarts the quiet period.
        repeat (3) step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));
        step(0, 1, 0, 1, 0, 1, mk(1, 0, 0, 0, 0, 0));
        repeat (6) step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));
        step(0, 1, 0, 1, 0, 1, mk(0, 0, 1, 0, 0, 0));
        repeat (4) step(0, 1, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
        repeat (6) step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));

        // Disabling detection while IDLE forces a wake and then holds ACTIVE.
        step(0, 0, 0, 1, 0, 0, mk(0, 0, 1, 0, 0, 0));
        repeat (4) step(0, 0, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 0));
        repeat (3) step(0, 0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0));

        // Underflow is sticky; an IDLE response leaves the state in IDLE.
        step(0, 0, 0, 1, 1, 0, mk(1, 0, 0, 0, 0, 0));
        step(0, 0, 1, 1, 0, 0, mk(1, 1, 0, 0, 0, 1));
        step(0, 1, 0, 1, 1, 0, mk(1, 0, 0, 0, 1, 1));
        repeat (6) step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 1));
        step(0, 1, 0, 1, 1, 0, mk(0, 0, 1, 0, 0, 1));
        step(0, 1, 1, 1, 0, 0, mk(0, 0, 1, 0, 0, 1));

        // Reset mid-WAKE returns to ACTIVE and clears err; a later stray rsp re-sets it.
        step(1, 1, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 1));
        step(0, 0, 0, 1, 1, 0, mk(1, 0, 0, 0, 0, 0));
        step(0, 0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
